score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 The block SHALL have parameter BLINK_HALF, default 25_000_000: number of clk cycles per blink half-period while gameOver is high.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port score, input, 10 bits: unsigned binary point count from the point counter.
REQ-005 The block SHALL have port gameOver, input, 1 bit: level, high while the game is over.
REQ-006 The block SHALL have ports HEX0, HEX1 and HEX2, each output, 7 bits: active-low 7-segment ones/tens/hundreds, bit0=seg a .. bit6=seg g.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-008 The block SHALL hold a 10-bit shadow register of the last accepted score.
REQ-009 The block SHALL implement states IDLE, CONV and LOAD.
REQ-010 In IDLE, when score != shadow, the block SHALL, on that edge, latch the clamped score into shadow and the shift register, zero the BCD accumulator, zero the iteration counter, and go to CONV.
REQ-011 Clamping: any score > 999 SHALL be treated as 999.
REQ-012 CONV SHALL perform exactly one double-dabble step per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by one; after 10 steps it SHALL go to LOAD.
REQ-013 LOAD SHALL write the three decoded digits into the HEX output registers and return to IDLE in one cycle.
REQ-014 HEX outputs SHALL show the new value exactly 12 rising edges after the first edge at which IDLE samples score != shadow.
REQ-015 busy SHALL be high in CONV and LOAD and low in IDLE.
REQ-016 Score changes during CONV/LOAD SHALL be ignored; on return to IDLE, a remaining difference SHALL start a new conversion on the next edge.
REQ-017 Leading-zero blanking: HEX2 SHALL be blank (7'b1111111) when hundreds=0; HEX1 SHALL be blank when hundreds=0 and tens=0; HEX0 SHALL always show a digit.
REQ-018 Segment codes 0-9 SHALL be 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
REQ-019 While gameOver is low, the blink counter SHALL be held at 0 and the visible flag at 1.
REQ-020 While gameOver is high, the blink counter SHALL count 0..BLINK_HALF-1 and toggle visible on wrap.
REQ-021 When visible=0, all HEX outputs SHALL read 7'b1111111; the digit registers SHALL be unaffected.
REQ-022 Conversions SHALL continue normally regardless of gameOver.

Reset
REQ-023 On reset the block SHALL set state=IDLE, shadow=0, BCD=0, iteration counter=0, blink counter=0, visible=1 and busy=0.
REQ-024 On reset HEX0 SHALL be 7'h40 and HEX1/HEX2 SHALL be 7'h7F.
REQ-025 Reset asserted during CONV SHALL abort the conversion with no HEX update.

Structure
REQ-026 Package score_display_pkg SHALL hold the state enum, the MAX_SCORE=999 constant, the SEG_BLANK constant and the digit segment table.
REQ-027 Combinational sub-module seg7_decoder SHALL map a 4-bit digit plus a blank input to 7 segment bits, instantiated three times.

Verification
REQ-028 Reset with score=0 -> HEX0=40, HEX1=7F, HEX2=7F, busy=0, and no conversion starts.
REQ-029 score 0->7 -> busy high for 11 cycles; 12 edges later HEX0=78, HEX1=7F, HEX2=7F.
REQ-030 score=305 -> HEX2=30, HEX1=40, HEX0=12; then score=1000 -> 999 shown (HEX2/HEX1/HEX0 = 10).
REQ-031 score 41->42 at the 3rd CONV cycle -> 41 shown first (HEX1=19, HEX0=79); a second conversion follows immediately and 42 is shown (HEX0=24).
REQ-032 BLINK_HALF=4, score=12, gameOver=1 -> HEX alternates 4 cycles digits / 4 cycles 7F; gameOver=0 -> digits steady on the next edge.
REQ-033 Reset pulse mid-CONV -> next cycle state IDLE, busy=0, HEX0=40; held score then reconverted after reset is released.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types, constants and helper functions for the score display block.
package score_display_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Largest score the three-digit display can show
  localparam logic [9:0] MAX_SCORE = 10'd999;

  // Active-low pattern with every segment dark
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Iteration counter value on the tenth (final) double-dabble step
  localparam logic [3:0] CONV_LAST = 4'd9;

  // Digit segment table: active-low, bit0 = seg a .. bit6 = seg g
  function automatic logic [6:0] seg_table(input logic [3:0] digit);
    logic [6:0] code_s;
    case (digit)
      4'd0:    code_s = 7'h40;
      4'd1:    code_s = 7'h79;
      4'd2:    code_s = 7'h24;
      4'd3:    code_s = 7'h30;
      4'd4:    code_s = 7'h19;
      4'd5:    code_s = 7'h12;
      4'd6:    code_s = 7'h02;
      4'd7:    code_s = 7'h78;
      4'd8:    code_s = 7'h00;
      4'd9:    code_s = 7'h10;
      default: code_s = SEG_BLANK;
    endcase
    return code_s;
  endfunction

  // Saturate a raw point count to what the display can represent
  function automatic logic [9:0] clamp_score(input logic [9:0] raw);
    logic [9:0] val_s;
    if (raw > MAX_SCORE) begin
      val_s = MAX_SCORE;
    end else begin
      val_s = raw;
    end
    return val_s;
  endfunction

  // Double-dabble correction of one BCD nibble ahead of the shift
  function automatic logic [3:0] nibble_adjust(input logic [3:0] nib);
    logic [3:0] out_s;
    if (nib >= 4'd5) begin
      out_s = nib + 4'd3;
    end else begin
      out_s = nib;
    end
    return out_s;
  endfunction

endpackage

// File: rtl/score_display_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module seg7_decoder
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank overrides the table lookup
  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg_table(digit);
    end
  end

endmodule

// File: rtl/score_display.sv
// Score display: converts a binary score to three 7-segment digits with a
// sequential double-dabble engine, leading-zero blanking and game-over blink.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 32'd25_000_000
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] score,
  input  logic       gameOver,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       busy
);

  localparam logic [31:0] BLINK_LAST = BLINK_HALF - 32'd1;

  state_t      state_r;
  state_t      state_next_s;

  logic [9:0]  score_clamped_s;
  logic        differs_s;
  logic        start_s;
  logic        step_s;
  logic        load_s;

  logic [9:0]  shadow_r;
  logic [9:0]  bin_r;
  logic [11:0] bcd_r;
  logic [3:0]  iter_r;
  logic [11:0] adj_s;
  logic [21:0] shift_s;

  logic [3:0]  dig0_r;
  logic [3:0]  dig1_r;
  logic [3:0]  dig2_r;
  logic [11:0] dig_next_s;

  logic [31:0] blink_cnt_r;
  logic [31:0] blink_cnt_next_s;
  logic        visible_r;
  logic        visible_next_s;

  logic        blank0_s;
  logic        blank1_s;
  logic        blank2_s;
  logic [6:0]  seg0_s;
  logic [6:0]  seg1_s;
  logic [6:0]  seg2_s;

  logic [6:0]  hex0_r;
  logic [6:0]  hex1_r;
  logic [6:0]  hex2_r;
  logic        busy_r;

  // Compare against the clamped score so an over-range input does not keep
  // retriggering conversions of the same saturated value.
  assign score_clamped_s = clamp_score(score);
  assign differs_s       = (score_clamped_s != shadow_r);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: start on a new score, ten steps, then one load cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (differs_s) begin
          state_next_s = ST_CONV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (iter_r == CONV_LAST) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_CONV;
        end
      end
      ST_LOAD: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    start_s = 1'b0;
    step_s  = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (differs_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_CONV: step_s  = 1'b1;
      ST_LOAD: load_s  = 1'b1;
      default: start_s = 1'b0;
    endcase
  end

  // One double-dabble step: correct each nibble, then shift {bcd, bin} left
  always_comb begin
    adj_s   = {nibble_adjust(bcd_r[11:8]),
               nibble_adjust(bcd_r[7:4]),
               nibble_adjust(bcd_r[3:0])};
    shift_s = {adj_s, bin_r} << 1'b1;
  end

  // Shadow, shift register, BCD accumulator and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= 10'd0;
      bin_r    <= 10'd0;
      bcd_r    <= 12'd0;
      iter_r   <= 4'd0;
    end else if (start_s) begin
      shadow_r <= score_clamped_s;
      bin_r    <= score_clamped_s;
      bcd_r    <= 12'd0;
      iter_r   <= 4'd0;
    end else if (step_s) begin
      bcd_r    <= shift_s[21:10];
      bin_r    <= shift_s[9:0];
      iter_r   <= iter_r + 4'd1;
    end
  end

  // Digit values that the display registers will hold after this edge
  always_comb begin
    if (load_s) begin
      dig_next_s = bcd_r;
    end else begin
      dig_next_s = {dig2_r, dig1_r, dig0_r};
    end
  end

  // Stored BCD digits, updated only when a conversion completes
  always_ff @(posedge clk) begin
    if (reset) begin
      dig0_r <= 4'd0;
      dig1_r <= 4'd0;
      dig2_r <= 4'd0;
    end else begin
      dig2_r <= dig_next_s[11:8];
      dig1_r <= dig_next_s[7:4];
      dig0_r <= dig_next_s[3:0];
    end
  end

  // Blink timing: idle at zero while playing, wrap and toggle while game over
  always_comb begin
    if (!gameOver) begin
      blink_cnt_next_s = 32'd0;
      visible_next_s   = 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_next_s = 32'd0;
      visible_next_s   = ~visible_r;
    end else begin
      blink_cnt_next_s = blink_cnt_r + 32'd1;
      visible_next_s   = visible_r;
    end
  end

  // Blink counter and visible flag
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= 32'd0;
      visible_r   <= 1'b1;
    end else begin
      blink_cnt_r <= blink_cnt_next_s;
      visible_r   <= visible_next_s;
    end
  end

  // Leading-zero blanking combined with blink suppression
  always_comb begin
    blank2_s = (dig_next_s[11:8] == 4'd0) || !visible_next_s;
    blank1_s = ((dig_next_s[11:8] == 4'd0) && (dig_next_s[7:4] == 4'd0))
               || !visible_next_s;
    blank0_s = !visible_next_s;
  end

  seg7_decoder u_dec0 (
    .digit (dig_next_s[3:0]),
    .blank (blank0_s),
    .seg   (seg0_s)
  );

  seg7_decoder u_dec1 (
    .digit (dig_next_s[7:4]),
    .blank (blank1_s),
    .seg   (seg1_s)
  );

  seg7_decoder u_dec2 (
    .digit (dig_next_s[11:8]),
    .blank (blank2_s),
    .seg   (seg2_s)
  );

  // Registered segment outputs and busy flag, aligned with the state they show
  always_ff @(posedge clk) begin
    if (reset) begin
      hex0_r <= 7'h40;
      hex1_r <= SEG_BLANK;
      hex2_r <= SEG_BLANK;
      busy_r <= 1'b0;
    end else begin
      hex0_r <= seg0_s;
      hex1_r <= seg1_s;
      hex2_r <= seg2_s;
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign HEX0 = hex0_r;
  assign HEX1 = hex1_r;
  assign HEX2 = hex2_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display against a decimal reference model.
module tb_score_display;

  localparam int unsigned BLINK = 4;

  logic       clk;
  logic       reset;
  logic [9:0] score;
  logic       gameOver;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic       busy;

  int n_checks;
  int n_fail;
  int shown;

  logic [6:0] seg_tab [0:9];

  score_display #(.BLINK_HALF(BLINK)) dut (
    .clk      (clk),
    .reset    (reset),
    .score    (score),
    .gameOver (gameOver),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_v(int v);
    return (v > 999) ? 999 : v;
  endfunction

  // Expected {HEX2, HEX1, HEX0} for a visible display of value v
  function automatic logic [20:0] model_hex(int v);
    int c;
    logic [6:0] s2, s1, s0;
    c  = clamp_v(v);
    s0 = seg_tab[c % 10];
    s1 = (c < 10)  ? 7'h7F : seg_tab[(c / 10) % 10];
    s2 = (c < 100) ? 7'h7F : seg_tab[c / 100];
    return {s2, s1, s0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    score = 10'd0;
    gameOver = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if ({HEX2, HEX1, HEX0} !== 21'({7'h7F, 7'h7F, 7'h40})) begin
      n_fail++;
      $display("FAIL reset_hex: got %h/%h/%h want 7f/7f/40", HEX2, HEX1, HEX0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(0)) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: busy=%b hex=%h/%h/%h want busy=0 7f/7f/40",
                 i, busy, HEX2, HEX1, HEX0);
      end
    end
    shown = 0;
  endtask

  task automatic test_single_digit();
    score = 10'd7;
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || {HEX2, HEX1, HEX0} !== model_hex(shown)) begin
        n_fail++;
        $display("FAIL busy_window edge %0d: busy=%b hex=%h/%h/%h want busy=1 old value",
                 i, busy, HEX2, HEX1, HEX0);
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(7)) begin
      n_fail++;
      $display("FAIL digit7: busy=%b hex=%h/%h/%h want busy=0 %h",
               busy, HEX2, HEX1, HEX0, model_hex(7));
    end
    shown = 7;
  endtask

  task automatic test_values();
    int vals [2];
    vals[0] = 305;
    vals[1] = 1000;
    for (int k = 0; k < 2; k++) begin
      score = 10'(vals[k]);
      repeat (12) tick();
      n_checks++;
      if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(vals[k])) begin
        n_fail++;
        $display("FAIL value_%0d: busy=%b hex=%h/%h/%h want busy=0 %h",
                 vals[k], busy, HEX2, HEX1, HEX0, model_hex(vals[k]));
      end
      shown = clamp_v(vals[k]);
    end
  endtask

  task automatic test_mid_change();
    score = 10'd41;
    repeat (3) tick();
    score = 10'd42;
    repeat (9) tick();
    n_checks++;
    if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(41)) begin
      n_fail++;
      $display("FAIL mid_first41: busy=%b hex=%h/%h/%h want busy=0 %h",
               busy, HEX2, HEX1, HEX0, model_hex(41));
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || {HEX2, HEX1, HEX0} !== model_hex(41)) begin
      n_fail++;
      $display("FAIL mid_restart: busy=%b hex=%h/%h/%h want busy=1 %h",
               busy, HEX2, HEX1, HEX0, model_hex(41));
    end
    repeat (11) tick();
    n_checks++;
    if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(42)) begin
      n_fail++;
      $display("FAIL mid_second42: busy=%b hex=%h/%h/%h want busy=0 %h",
               busy, HEX2, HEX1, HEX0, model_hex(42));
    end
    shown = 42;
  endtask

  task automatic test_random();
    int v;
    logic exp_busy;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = shown;
      end else begin
        v = int'($urandom_range(0, 1023));
      end
      exp_busy = (clamp_v(v) != shown);
      score = 10'(v);
      tick();
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rand_start score=%0d: busy=%b want %b", v, busy, exp_busy);
      end
      repeat (11) tick();
      n_checks++;
      if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(v)) begin
        n_fail++;
        $display("FAIL rand_value score=%0d: busy=%b hex=%h/%h/%h want busy=0 %h",
                 v, busy, HEX2, HEX1, HEX0, model_hex(v));
      end
      shown = clamp_v(v);
    end
  endtask

  task automatic test_blink();
    logic [20:0] exp;
    score = 10'd12;
    repeat (12) tick();
    n_checks++;
    if ({HEX2, HEX1, HEX0} !== model_hex(12)) begin
      n_fail++;
      $display("FAIL blink_setup: hex=%h/%h/%h want %h", HEX2, HEX1, HEX0, model_hex(12));
    end
    gameOver = 1'b1;
    score = 10'd34;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (((k / int'(BLINK)) % 2) == 0) begin
        exp = model_hex((k >= 12) ? 34 : 12);
      end else begin
        exp = {7'h7F, 7'h7F, 7'h7F};
      end
      n_checks++;
      if ({HEX2, HEX1, HEX0} !== exp) begin
        n_fail++;
        $display("FAIL blink edge %0d: hex=%h/%h/%h want %h", k, HEX2, HEX1, HEX0, exp);
      end
    end
    gameOver = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({HEX2, HEX1, HEX0} !== model_hex(34)) begin
        n_fail++;
        $display("FAIL blink_off cyc %0d: hex=%h/%h/%h want %h",
                 k, HEX2, HEX1, HEX0, model_hex(34));
      end
    end
    shown = 34;
  endtask

  task automatic test_reset_mid_conv();
    score = 10'd500;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(0)) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b hex=%h/%h/%h want busy=0 7f/7f/40",
               busy, HEX2, HEX1, HEX0);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || {HEX2, HEX1, HEX0} !== model_hex(0)) begin
      n_fail++;
      $display("FAIL rst_restart: busy=%b hex=%h/%h/%h want busy=1 7f/7f/40",
               busy, HEX2, HEX1, HEX0);
    end
    repeat (11) tick();
    n_checks++;
    if (busy !== 1'b0 || {HEX2, HEX1, HEX0} !== model_hex(500)) begin
      n_fail++;
      $display("FAIL rst_reconvert: busy=%b hex=%h/%h/%h want busy=0 %h",
               busy, HEX2, HEX1, HEX0, model_hex(500));
    end
    shown = 500;
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    n_checks = 0;
    n_fail   = 0;
    shown    = 0;
    reset    = 1'b1;
    score    = 10'd0;
    gameOver = 1'b0;

    test_reset();
    test_single_digit();
    test_values();
    test_mid_change();
    test_random();
    test_blink();
    test_reset_mid_conv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
